// File: rtl/ws2812_rx_apb.sv
// WS2812 pulse-width line receiver: decodes bits by high-pulse length into a
// 24-bit pixel capture buffer and exposes buffer plus capture status over APB3.
module ws2812_rx_apb #(
  parameter int NUM_PIXELS   = 24,
  parameter int BIT_THRESH   = 61,
  parameter int MIN_HIGH     = 10,
  parameter int MAX_HIGH     = 120,
  parameter int RESET_CYCLES = 5000
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        din
);
  localparam int          PIX_W    = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [15:0] C_THRESH = 16'(BIT_THRESH);
  localparam logic [15:0] C_MIN    = 16'(MIN_HIGH);
  localparam logic [15:0] C_MAX1   = 16'(MAX_HIGH + 1);
  localparam logic [15:0] C_RESET  = 16'(RESET_CYCLES);
  localparam logic [9:0]  C_TOTAL  = 10'(NUM_PIXELS * 24);
  localparam logic [5:0]  C_NPIX   = 6'(NUM_PIXELS);

  typedef enum logic [1:0] {S_SYNC, S_GAP, S_HIGH, S_LOW} state_t;

  state_t             r_state, w_state_next;
  logic               r_din_s1, r_din_s2, r_din_s3;
  logic [15:0]        r_cnt;
  logic [9:0]         r_bit_idx;
  logic [PIX_W-1:0]   r_pix_idx;
  logic [4:0]         r_bit_pos;
  logic               r_accept;
  logic               r_frame_done, r_overrun, r_pulse_err, r_overflow;
  logic [9:0]         r_bit_count;
  logic [15:0]        r_frame_count;
  logic [23:0]        r_pix [NUM_PIXELS];

  logic               w_rise, w_fall;
  logic               w_frame_start, w_bit_valid, w_frame_end, w_pulse_err;
  logic               w_bit_val, w_in_range, w_store, w_busy;
  logic [3:0]         w_clr;
  logic [PIX_W-1:0]   w_rd_idx;
  logic               w_unused;

  assign PREADY   = 1'b1;
  assign PSLVERR  = 1'b0;
  assign w_unused = ^{PWDATA[31:4], PADDR[31:8], PADDR[1:0]};

  assign w_rise     = r_din_s2 & ~r_din_s3;
  assign w_fall     = ~r_din_s2 & r_din_s3;
  assign w_bit_val  = (r_cnt >= C_THRESH);
  assign w_in_range = (r_bit_idx < C_TOTAL);
  assign w_store    = w_bit_valid & r_accept & w_in_range;
  assign w_busy     = (r_state == S_HIGH) || (r_state == S_LOW);
  assign w_clr      = (PSEL && PENABLE && PWRITE && PADDR[7:2] == 6'h20) ? PWDATA[3:0] : 4'h0;

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      {r_din_s1, r_din_s2, r_din_s3} <= 3'b000;
      r_cnt <= '0;
    end else begin
      r_din_s1 <= din;
      r_din_s2 <= r_din_s1;
      r_din_s3 <= r_din_s2;
      if (w_rise || w_fall) r_cnt <= '0;
      else if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) r_state <= S_SYNC;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_frame_start = 1'b0;
    w_bit_valid   = 1'b0;
    w_frame_end   = 1'b0;
    w_pulse_err   = 1'b0;
    case (r_state)
      // the just-fell cycle still carries the old high count, so require two low samples
      S_SYNC: if (!r_din_s2 && !r_din_s3 && r_cnt >= C_RESET) w_state_next = S_GAP;
      S_GAP: if (w_rise) begin
        w_frame_start = 1'b1;
        w_state_next  = S_HIGH;
      end
      S_HIGH: if (w_fall) begin
        if (r_cnt < C_MIN) begin
          w_pulse_err  = 1'b1;
          w_state_next = S_SYNC;
        end else begin
          w_bit_valid  = 1'b1;
          w_state_next = S_LOW;
        end
      end else if (r_cnt >= C_MAX1) begin
        w_pulse_err  = 1'b1;
        w_state_next = S_SYNC;
      end
      S_LOW: if (w_rise) begin
        w_state_next = S_HIGH;
      end else if (r_cnt >= C_RESET) begin
        w_frame_end  = 1'b1;
        w_state_next = S_GAP;
      end
      default: w_state_next = S_SYNC;
    endcase
  end

  // pixel/bit position tracked incrementally to avoid a divide-by-24
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_bit_idx <= '0;
      r_pix_idx <= '0;
      r_bit_pos <= '0;
      r_accept  <= 1'b0;
    end else if (w_frame_start) begin
      r_bit_idx <= '0;
      r_pix_idx <= '0;
      r_bit_pos <= '0;
      r_accept  <= ~r_frame_done;
    end else if (w_bit_valid) begin
      if (r_bit_idx != 10'h3FF) r_bit_idx <= r_bit_idx + 10'd1;
      if (w_in_range) begin
        if (r_bit_pos == 5'd23) begin
          r_bit_pos <= '0;
          r_pix_idx <= r_pix_idx + 1'b1;
        end else begin
          r_bit_pos <= r_bit_pos + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      for (int i = 0; i < NUM_PIXELS; i++) r_pix[i] <= '0;
    end else if (w_store) begin
      r_pix[r_pix_idx][r_bit_pos] <= w_bit_val;
    end
  end

  // hardware set takes priority over a same-cycle software clear
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_frame_done  <= 1'b0;
      r_overrun     <= 1'b0;
      r_pulse_err   <= 1'b0;
      r_overflow    <= 1'b0;
      r_bit_count   <= '0;
      r_frame_count <= '0;
    end else begin
      r_frame_done <= (w_frame_end & r_accept) | (r_frame_done & ~w_clr[0]);
      r_overrun    <= (w_frame_start & r_frame_done) | (r_overrun & ~w_clr[1]);
      r_pulse_err  <= w_pulse_err | (r_pulse_err & ~w_clr[2]);
      r_overflow   <= (w_bit_valid & r_accept & ~w_in_range) | (r_overflow & ~w_clr[3]);
      if (w_frame_end && r_accept) begin
        r_bit_count   <= w_in_range ? r_bit_idx : C_TOTAL;
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign w_rd_idx = PADDR[2 +: PIX_W];

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      if (!PADDR[7]) begin
        if ({1'b0, PADDR[6:2]} < C_NPIX) PRDATA = {8'h00, r_pix[w_rd_idx]};
      end else if (PADDR[6:2] == 5'd0) begin
        PRDATA = {6'h00, r_bit_count, 11'h000, w_busy,
                  r_overflow, r_pulse_err, r_overrun, r_frame_done};
      end else if (PADDR[6:2] == 5'd1) begin
        PRDATA = {16'h0000, r_frame_count};
      end
    end
  end
endmodule

// File: tb/tb_ws2812_rx_apb.sv
// Directed bench for ws2812_rx_apb: drives pulse-width frames on din and
// checks the pixel buffer and status registers over APB.
module tb_ws2812_rx_apb;
  logic        PCLK = 1'b0;
  logic        PRESERN = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0, din = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  int          n_checks = 0;
  int          n_pass = 0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] exp;
  } rd_vec_t;

  always #5 PCLK = ~PCLK;

  ws2812_rx_apb dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .din(din)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else begin
      n_pass++;
      $display("  ok %s = %h", name, got);
    end
  endtask

  task automatic level(input logic v, input int n);
    din = v;
    repeat (n) @(negedge PCLK);
  endtask

  // slow: 81/45 and 41/85 timing; fast: 66 or 14 high, 3 low
  task automatic send_bit(input logic b, input logic slow);
    if (slow) begin
      level(1'b1, b ? 81 : 41);
      level(1'b0, b ? 45 : 85);
    end else begin
      level(1'b1, b ? 66 : 14);
      level(1'b0, 3);
    end
  endtask

  task automatic send_word(input logic [23:0] w, input logic slow);
    for (int i = 0; i < 24; i++) send_bit(w[i], slow);
  endtask

  task automatic gap();
    level(1'b0, 5005);
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 d = PRDATA;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(a, d);
    check(name, d, exp);
  endtask

  function automatic logic [23:0] pat(input int i);
    pat = (24'h000001 << i) ^ 24'h810000;
  endfunction

  initial begin
    rd_vec_t tbl [9];
    tbl[0] = '{"f2_pix0",   32'h00, 32'h00ABCDEF};
    tbl[1] = '{"f2_pix1",   32'h04, 32'h00123456};
    tbl[2] = '{"f2_pix2",   32'h08, 32'h00000000};
    tbl[3] = '{"f2_pix23",  32'h5C, 32'h00000000};
    tbl[4] = '{"f2_status", 32'h80, 32'h00300001};
    tbl[5] = '{"f2_fcount", 32'h84, 32'h00000002};
    tbl[6] = '{"f2_idx24",  32'h60, 32'h00000000};
    tbl[7] = '{"f2_unmap",  32'h88, 32'h00000000};
    tbl[8] = '{"f2_hi_unm", 32'hC0, 32'h00000000};

    // reset state
    @(negedge PCLK);
    repeat (2) @(negedge PCLK);
    rd_check("rst_status", 32'h80, 32'h0);
    rd_check("rst_fcount", 32'h84, 32'h0);
    rd_check("rst_pix0",   32'h00, 32'h0);
    check("pready_pslverr", {30'h0, PREADY, PSLVERR}, 32'h2);
    PRESERN = 1'b1;

    // frame 1: alternating bits with slow timing
    gap();
    send_word(24'h555555, 1'b1);
    gap();
    rd_check("f1_pix0",   32'h00, 32'h00555555);
    rd_check("f1_status", 32'h80, 32'h00180001);
    rd_check("f1_fcount", 32'h84, 32'h1);
    apb_write(32'h80, 32'h1);
    rd_check("f1_clr",    32'h80, 32'h00180000);

    // frame 2: two pixels, table-driven readback
    send_word(24'hABCDEF, 1'b0);
    send_word(24'h123456, 1'b0);
    gap();
    for (int i = 0; i < 9; i++) rd_check(tbl[i].name, tbl[i].addr, tbl[i].exp);
    apb_write(32'h80, 32'h1);
    rd_check("f2_clr", 32'h80, 32'h00300000);

    // frame 3 captured, frame 4 dropped while FRAME_DONE still set
    send_word(24'h111111, 1'b0);
    gap();
    rd_check("f3_pix0",   32'h00, 32'h00111111);
    rd_check("f3_status", 32'h80, 32'h00180001);
    send_word(24'h222222, 1'b0);
    gap();
    rd_check("f4_pix0",   32'h00, 32'h00111111);
    rd_check("f4_status", 32'h80, 32'h00180003);
    rd_check("f4_fcount", 32'h84, 32'h3);
    apb_write(32'h80, 32'h3);
    send_word(24'h333333, 1'b0);
    gap();
    rd_check("f5_pix0",   32'h00, 32'h00333333);
    rd_check("f5_status", 32'h80, 32'h00180001);
    rd_check("f5_fcount", 32'h84, 32'h4);

    // glitch after 5 bits aborts the frame
    apb_write(32'h80, 32'hF);
    for (int i = 0; i < 5; i++) send_bit(1'(24'h444444 >> i), 1'b0);
    level(1'b1, 5);
    level(1'b0, 10);
    rd_check("gl_status", 32'h80, 32'h00180004);
    rd_check("gl_pix0",   32'h00, 32'h00333324);
    rd_check("gl_fcount", 32'h84, 32'h4);
    gap();
    send_word(24'h444444, 1'b0);
    gap();
    rd_check("gl_next_pix0",   32'h00, 32'h00444444);
    rd_check("gl_next_status", 32'h80, 32'h00180005);
    rd_check("gl_next_fcount", 32'h84, 32'h5);

    // 25 pixels: last one overflows
    apb_write(32'h80, 32'hF);
    for (int p = 0; p < 25; p++) send_word(pat(p), 1'b0);
    gap();
    rd_check("ov_status", 32'h80, 32'h02400009);
    rd_check("ov_fcount", 32'h84, 32'h6);
    for (int p = 0; p < 24; p++) rd_check($sformatf("ov_pix%0d", p), 32'(p * 4), {8'h0, pat(p)});
    rd_check("ov_idx24", 32'h60, 32'h0);

    // reset asserted in the middle of a frame
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    rd_check("mid_status", 32'h80, 32'h0240001B);
    level(1'b1, 20);
    PRESERN = 1'b0;
    rd_check("mr_status", 32'h80, 32'h0);
    rd_check("mr_fcount", 32'h84, 32'h0);
    rd_check("mr_pix0",   32'h00, 32'h0);
    PRESERN = 1'b1;
    level(1'b0, 1000);
    send_word(24'h777777, 1'b0);
    gap();
    rd_check("mr_short_status", 32'h80, 32'h0);
    rd_check("mr_short_pix0",   32'h00, 32'h0);
    send_word(24'h777777, 1'b0);
    gap();
    rd_check("mr_cap_pix0",   32'h00, 32'h00777777);
    rd_check("mr_cap_status", 32'h80, 32'h00180001);
    rd_check("mr_cap_fcount", 32'h84, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ws2812_rx_apb.md
Name: ws2812_rx_apb

Overview:
- Single-wire WS2812-format receiver: the other end of the LED strip transmitter.
- Samples a pulse-width-coded serial line (the transmitter's LED output in loopback, or the DOUT of the last pixel) and decodes bits by high-pulse width.
- Stores decoded 24-bit pixel words in a register buffer and exposes them plus capture status to the processor as an APB3 slave, for strip self-test and bring-up.

Parameters:
- NUM_PIXELS, 24, pixel words stored (24 bits each).
- BIT_THRESH, 61, high-pulse length in PCLK cycles; length >= BIT_THRESH decodes as 1, otherwise 0.
- MIN_HIGH, 10, shortest legal high pulse in cycles; shorter is a glitch error.
- MAX_HIGH, 120, longest legal high pulse in cycles; longer is an error.
- RESET_CYCLES, 5000, low time in cycles that marks a frame boundary (latch gap).

Ports:
- PCLK  in  1  clock.
- PRESERN  in  1  asynchronous active-low reset.
- PSEL  in  1  APB3 select.
- PENABLE  in  1  APB3 access phase.
- PWRITE  in  1  APB3 write/read.
- PADDR  in  32  APB3 address; only PADDR[7:2] decoded.
- PWDATA  in  32  APB3 write data.
- PRDATA  out  32  APB3 read data.
- PREADY  out  1  tied 1.
- PSLVERR  out  1  tied 0.
- din  in  1  asynchronous serial line input.

Behaviour:
- Reset (PRESERN=0, async): all status bits, counters, buffer and FSM cleared; FSM = SYNC; PRDATA = 0.
- din passes a 2-flop synchronizer; edges are detected on the synchronized signal. Decode latency = 3 cycles after din falls.
- Pulse counter: 16 bits, saturating; cleared on every synchronized edge.
- FSM states:
  - SYNC: wait until low has lasted >= RESET_CYCLES, then go to GAP. Any high resets the low count.
  - GAP: on a rising edge, start the frame: bit_idx = 0, accept = ~FRAME_DONE, go to HIGH.
  - HIGH: on a falling edge with count < MIN_HIGH, set PULSE_ERR and go to SYNC. Otherwise decode the bit (1 if count >= BIT_THRESH), store it and go to LOW. If count reaches MAX_HIGH+1 while din is still high, set PULSE_ERR and go to SYNC.
  - LOW: on a rising edge, go to HIGH. If low count reaches RESET_CYCLES, end the frame and go to GAP.
- Bit store: stream bit k goes to pixel k/24, bit k%24, LSB first (first received bit is pixel 0 bit 0).
  - A bit is stored only if accept=1 and k < NUM_PIXELS*24.
  - If k >= NUM_PIXELS*24 and accept=1, set OVERFLOW and drop the bit.
  - bit_idx is 10 bits and saturates at 1023.
- Frame end with accept=1:
  - Set FRAME_DONE, latch BIT_COUNT = min(bit_idx, NUM_PIXELS*24), FRAME_COUNT += 1 (16-bit, wraps 0xFFFF->0).
  - A partial trailing pixel keeps its received bits; its remaining bits hold old values.
- Frame end with accept=0: no status change except OVERRUN.
  - OVERRUN is set at frame start when FRAME_DONE=1 (a frame was dropped because software had not acknowledged).
- An aborted frame (PULSE_ERR) never sets FRAME_DONE and does not bump FRAME_COUNT. Buffer bits already written stay.
- Clearing FRAME_DONE mid-frame does not enable capture until the next frame start.
- APB read (PSEL & ~PWRITE): PRDATA is combinational from PADDR, valid in setup and access phases.
  - PADDR[7]=0, index PADDR[6:2] < NUM_PIXELS: {8'h0, pixel[index]}.
  - PADDR[7]=0, index >= NUM_PIXELS: 0.
  - 0x80 STATUS: [0] FRAME_DONE, [1] OVERRUN, [2] PULSE_ERR, [3] OVERFLOW, [4] FSM busy (state HIGH or LOW), [25:16] BIT_COUNT, others 0.
  - 0x84: {16'h0, FRAME_COUNT}.
  - Other addresses: 0.
- APB write (PSEL & PENABLE & PWRITE):
  - 0x80: write-1-to-clear bits [3:0].
  - All other writes ignored; the pixel buffer is read-only.
- Simultaneous hardware set and software clear of the same status bit in one cycle: set wins.
- No wait states, no errors.

Test Plan:
- Reset, din=0 for 5000 cycles, then 24 bits alternating 1/0 (high 81/low 45, high 41/low 85), then 5000 low -> pixel0=0x555555, STATUS=0x00180001, FRAME_COUNT=1.
- Two pixels 0xABCDEF, 0x123456 sent, then W1C 0x1 -> read 0x00 / 0x04 match; STATUS[0]=0 after write; BIT_COUNT=48.
- Second frame sent without clearing FRAME_DONE -> buffer unchanged, OVERRUN=1, FRAME_COUNT unchanged; clear, send again -> new data captured.
- 5-cycle glitch high mid-frame -> PULSE_ERR=1, FRAME_DONE=0, FSM in SYNC; the next valid frame after a 5000-cycle gap decodes correctly.
- 25 pixels (600 bits) -> OVERFLOW=1, BIT_COUNT=576, pixels 0..23 correct, read 0x60 = 0.
- Assert PRESERN low mid-frame -> all registers 0 immediately; a full 5000-cycle low gap is required before the next frame is captured.
